// File: rtl/cond_pkg.sv
// ---------------------------------------------------------------------------
// cond_pkg -- shared definitions for the condition evaluation unit.
//   cond_e          : 4-bit condition field encodings (EQ .. NV)
//   FLAG_Z..FLAG_V  : bit positions of the flags inside a {Z,C,N,V} nibble
// ---------------------------------------------------------------------------
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_decode.sv
// ---------------------------------------------------------------------------
// cond_decode -- single-lane condition evaluation.
//   cond  [3:0] : condition field
//   flags [3:0] : {Z,C,N,V}
//   pass        : 1 when the condition holds for the given flags
// Conditions come in complementary pairs: cond[3:1] selects the base
// predicate and cond[0] inverts it. The 111x pair works out naturally:
// AL is base 1, NV is its inverse.
// ---------------------------------------------------------------------------
module cond_decode
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic z, c, n, v;
    logic base;

    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign n = flags[FLAG_N];
    assign v = flags[FLAG_V];

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves base unassigned (no latch).
        base = 1'b0;
        case (cond[3:1])
            3'b000:  base = z;
            3'b001:  base = c;
            3'b010:  base = n;
            3'b011:  base = v;
            3'b100:  base = c & ~z;
            3'b101:  base = (n == v);
            3'b110:  base = ~z & (n == v);
            3'b111:  base = 1'b1;
            default: base = 1'b0;
        endcase
    end

    assign pass = base ^ cond[0];

endmodule

// File: rtl/cond_eval_unit.sv
// ---------------------------------------------------------------------------
// cond_eval_unit -- multi-lane condition-code evaluation with status
// register, optional output register and saturating pass/fail statistics.
//   clk, rst_n            : clock, async active-low reset
//   status_wr_en/status_in: status write-back {Z,C,N,V} (bypassed same cycle)
//   in_valid, cond_in     : per-lane valid and 4-bit condition field
//   stall, flush          : hold / squash the output stage
//   out_valid, exec       : per-lane result valid and condition-passed
//   status_out            : current status register
//   pass_cnt, fail_cnt    : saturating counts of accepted lanes by result
// ---------------------------------------------------------------------------
module cond_eval_unit
    import cond_pkg::*;
#(
    parameter int LANES   = 2,
    parameter int REG_OUT = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               status_wr_en,
    input  logic [3:0]         status_in,
    input  logic [LANES-1:0]   in_valid,
    input  logic [4*LANES-1:0] cond_in,
    input  logic               stall,
    input  logic               flush,
    output logic [LANES-1:0]   out_valid,
    output logic [LANES-1:0]   exec,
    output logic [3:0]         status_out,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt
);

    // Three spare bits hold a full LANES<=4 increment without overflow.
    localparam int SUM_W = CNT_W + 3;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [3:0]       status_q;
    logic [3:0]       eval_flags;
    logic [LANES-1:0] pass;
    logic [LANES-1:0] ov_w;
    logic [LANES-1:0] ex_w;
    logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q;
    logic [CNT_W-1:0] pass_next, fail_next;
    logic [SUM_W-1:0] pass_sum, fail_sum;
    logic             accept;

    // A write-back in the same cycle is visible to this cycle's conditions.
    assign eval_flags = status_wr_en ? status_in : status_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            status_q <= 4'b0000;
        else if (status_wr_en)
            status_q <= status_in;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cond_decode u_decode (
            .cond  (cond_in[4*i +: 4]),
            .flags (eval_flags),
            .pass  (pass[i])
        );
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic [LANES-1:0] ov_q, ex_q;

        // Flush wins over stall; exec is cleared together with valid.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ov_q <= '0;
                ex_q <= '0;
            end else if (flush) begin
                ov_q <= '0;
                ex_q <= '0;
            end else if (!stall) begin
                ov_q <= in_valid;
                ex_q <= in_valid & pass;
            end
        end

        assign ov_w = ov_q;
        assign ex_w = ex_q;
    end else begin : g_comb_out
        assign ov_w = in_valid & ~{LANES{flush}};
        assign ex_w = ov_w & pass;
    end

    // A lane is counted only on the edge where the output stage hands it on.
    assign accept = ~stall & ~flush;

    always_comb begin
        pass_sum = {3'b000, pass_cnt_q};
        fail_sum = {3'b000, fail_cnt_q};
        for (int i = 0; i < LANES; i++) begin
            pass_sum = pass_sum + SUM_W'(ov_w[i] &  ex_w[i]);
            fail_sum = fail_sum + SUM_W'(ov_w[i] & ~ex_w[i]);
        end
        pass_next = (pass_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : pass_sum[CNT_W-1:0];
        fail_next = (fail_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : fail_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else if (accept) begin
            pass_cnt_q <= pass_next;
            fail_cnt_q <= fail_next;
        end
    end

    assign out_valid  = ov_w;
    assign exec       = ex_w;
    assign status_out = status_q;
    assign pass_cnt   = pass_cnt_q;
    assign fail_cnt   = fail_cnt_q;

endmodule

// File: doc/cond_eval_unit.md
COND_EVAL_UNIT -- requirements
Module: cond_eval_unit

Interface
REQ-001 The block SHALL have parameter LANES, default 2, number of condition codes evaluated per cycle (1..4).
REQ-002 The block SHALL have parameter REG_OUT, default 1, where 1 = registered results and 0 = combinational results.
REQ-003 The block SHALL have parameter CNT_W, default 16, width of the pass/fail statistics counters.
REQ-004 The block SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 The block SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port status_wr_en  in  1  load status_in into the status register (S-bit write-back).
REQ-007 The block SHALL have port status_in  in  4  new flags {Z,C,N,V}, in bits [3:0].
REQ-008 The block SHALL have port in_valid  in  LANES  per-lane instruction valid.
REQ-009 The block SHALL have port cond_in  in  4*LANES  per-lane condition field; lane i occupies [4i+3:4i].
REQ-010 The block SHALL have port stall  in  1  hold the output stage.
REQ-011 The block SHALL have port flush  in  1  squash the output stage.
REQ-012 The block SHALL have port out_valid  out  LANES  per-lane result valid.
REQ-013 The block SHALL have port exec  out  LANES  per-lane condition-passed result.
REQ-014 The block SHALL have port status_out  out  4  current status register {Z,C,N,V}.
REQ-015 The block SHALL have port pass_cnt  out  CNT_W  count of valid lanes that passed.
REQ-016 The block SHALL have port fail_cnt  out  CNT_W  count of valid lanes that failed.

Function
REQ-017 Condition decode SHALL be EQ 0000=Z; NE=~Z; CS 0010=C; CC=~C; MI 0100=N; PL=~N; VS 0110=V; VC=~V.
REQ-018 Condition decode SHALL continue HI 1000=C&~Z; LS=~C|Z; GE 1010=(N==V); LT=(N!=V); GT 1100=~Z&(N==V); LE=Z|(N!=V); AL 1110=1; NV 1111=0.
REQ-019 Evaluation flags SHALL be status_in when status_wr_en=1 (same-cycle bypass), and the status register otherwise.
REQ-020 Every lane SHALL use the same evaluation flags within a cycle.
REQ-021 The status register SHALL load status_in on the clock edge when status_wr_en=1, independent of stall and flush.
REQ-022 When REG_OUT=1, out_valid/exec SHALL register in_valid/evaluated result one cycle later (latency 1).
REQ-023 When REG_OUT=1 and stall=1, out_valid and exec SHALL hold their values.
REQ-024 When REG_OUT=1 and flush=1, out_valid SHALL clear on the next edge; flush SHALL take priority over stall.
REQ-025 When REG_OUT=0, out_valid SHALL equal in_valid & ~{LANES{flush}} combinationally, and stall SHALL have no effect.
REQ-026 exec SHALL be 0 for any lane whose out_valid is 0.
REQ-027 Counters SHALL add the number of lanes with out_valid=1 that are accepted this cycle (stall=0, flush=0), split by exec, counting each lane once.
REQ-028 Counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-029 The per-cycle counter increment SHALL be summed in a width of CNT_W+3 before saturation.

Reset
REQ-030 On rst_n=0, status register, out_valid, exec, pass_cnt and fail_cnt SHALL clear to 0 immediately, regardless of clk.
REQ-031 An operation in flight at reset SHALL be lost, with no counter update.
REQ-032 The first edge after rst_n rises SHALL behave as a normal cycle.

Structure
REQ-033 Condition-code constants (EQ..NV) and the flag bit indices Z=3, C=2, N=1, V=0 SHALL live in shared package cond_pkg.
REQ-034 Single-lane decode SHALL be sub-module cond_decode (cond[3:0], flags[3:0] -> pass), instantiated LANES times by generate.

Verification
REQ-035 Bench SHALL cover: reset, status_wr_en=1 with status_in=4'b1000, next cycle cond_in lane0=EQ, lane1=NE, both valid -> one cycle later exec=2'b01, status_out=4'b1000.
REQ-036 Bench SHALL cover bypass: status reg=0, same cycle status_wr_en=1, status_in=4'b0011 (N=1,V=1), lane0=GE -> exec[0]=1 next cycle.
REQ-037 Bench SHALL cover LE boundary: flags Z=1,N=0,V=0 -> LE=1, GT=0; flags Z=0,N=1,V=0 -> LE=1, GE=0.
REQ-038 Bench SHALL cover stall then flush: result exec=2'b11 held 3 cycles under stall with counters frozen; flush+stall together -> out_valid=0 next edge, with no count.
REQ-039 Bench SHALL cover counter saturation: CNT_W=4, pass_cnt preloaded to 14 via traffic, then two lanes AL valid -> pass_cnt=15 and stays 15.
REQ-040 Bench SHALL cover async reset: rst_n low mid-cycle between edges -> all outputs 0 before the next clk edge; AL and NV across all lanes -> exec=1 and exec=0 respectively.
